// File: rtl/data_worker.sv
// -----------------------------------------------------------------------------
// data_worker
//
// AHB-Lite master that moves one payload (default 128 bits) as a single
// incrementing burst of bus-width words (default INCR4 of 32-bit words).
// An internal engine supplies address, write data and direction and holds
// I_go high until O_done pulses. A read job returns the assembled payload on
// O_int_rdata, qualified by O_int_rdata_valid.
//
// Optional feature: define DATA_WORKER_TIMEOUT_EN to abort a job after
// pMAX_TRANSFER_WAIT_COUNT consecutive wait states on one phase. With the
// macro undefined the block waits indefinitely for the slave.
//
// Ports
//   clk                clock
//   rst_n              synchronous reset, active-high (despite the name)
//   I_go               job request level, held until O_done
//   I_int_write        1 = write job, 0 = read job
//   I_int_addr         burst start address
//   I_int_wdata        write payload
//   O_int_rdata        read payload
//   O_int_rdata_valid  O_int_rdata holds a completed read
//   O_done             one-cycle job completion pulse
//   O_h*               AHB-Lite master address/control/write-data outputs
//   I_hrdata           AHB read data
//   I_hreadyout        slave ready; 0 stalls every phase
//   I_hready           unused
//   I_hresp            slave response, bit 0 = ERROR
// -----------------------------------------------------------------------------
module data_worker #(
  parameter int pAHB_ADDR_WIDTH   = 32,
  parameter int pAHB_DATA_WIDTH   = 32,
  parameter int pAHB_BURST_WIDTH  = 3,
  parameter int pAHB_PROT_WIDTH   = 4,
  parameter int pAHB_SIZE_WIDTH   = 3,
  parameter int pAHB_TRANS_WIDTH  = 2,
  parameter int pAHB_HRESP_WIDTH  = 2,
  parameter logic [pAHB_PROT_WIDTH-1:0]  pAHB_HPROT_VALUE  = 4'b0011,
  parameter logic [pAHB_SIZE_WIDTH-1:0]  pAHB_HSIZE_VALUE  = 3'b010,
  parameter logic [pAHB_BURST_WIDTH-1:0] pAHB_HBURST_VALUE = 3'b011,
  parameter logic pAHB_HMASTLOCK_VALUE = 1'b1,
  parameter logic pAHB_HNONSEC_VALUE   = 1'b0,
  parameter int pPAYLOAD_SIZE_BITS       = 128,
  parameter int pMAX_TRANSFER_WAIT_COUNT = 16,
  parameter int pREVERSE_WORD_ORDER      = 1,
  parameter int pREVERSE_BYTE_ORDER      = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          I_go,
  input  logic                          I_int_write,
  input  logic [pAHB_ADDR_WIDTH-1:0]    I_int_addr,
  input  logic [pPAYLOAD_SIZE_BITS-1:0] I_int_wdata,
  output logic [pPAYLOAD_SIZE_BITS-1:0] O_int_rdata,
  output logic                          O_int_rdata_valid,
  output logic                          O_done,
  output logic [pAHB_ADDR_WIDTH-1:0]    O_haddr,
  output logic [pAHB_BURST_WIDTH-1:0]   O_hburst,
  output logic                          O_hmastlock,
  output logic [pAHB_PROT_WIDTH-1:0]    O_hprot,
  output logic                          O_hnonsec,
  output logic [pAHB_SIZE_WIDTH-1:0]    O_hsize,
  output logic [pAHB_TRANS_WIDTH-1:0]   O_htrans,
  output logic [pAHB_DATA_WIDTH-1:0]    O_hwdata,
  output logic                          O_hwrite,
  input  logic [pAHB_DATA_WIDTH-1:0]    I_hrdata,
  input  logic                          I_hreadyout,
  input  logic                          I_hready,
  input  logic [pAHB_HRESP_WIDTH-1:0]   I_hresp
);

  localparam int BEATS      = pPAYLOAD_SIZE_BITS / pAHB_DATA_WIDTH;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int NBYTES     = pAHB_DATA_WIDTH / 8;
  localparam int ADDR_SHIFT = $clog2(NBYTES);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [pAHB_TRANS_WIDTH-1:0] TRANS_IDLE   = '0;
  localparam logic [pAHB_TRANS_WIDTH-1:0] TRANS_NONSEQ = pAHB_TRANS_WIDTH'(2);
  localparam logic [pAHB_TRANS_WIDTH-1:0] TRANS_SEQ    = pAHB_TRANS_WIDTH'(3);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BURST,
    ST_LAST,
    ST_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [BEAT_W-1:0]             beat_q, beat_d;
  logic [pAHB_ADDR_WIDTH-1:0]    addr_q;
  logic [pPAYLOAD_SIZE_BITS-1:0] wdata_q;
  logic                          write_q;
  logic                          armed_q;
  logic [pPAYLOAD_SIZE_BITS-1:0] rdata_q;
  logic                          rvalid_q;

  logic                          accept;
  logic                          finish_ok;
  logic                          data_phase;
  logic                          capture;
  logic [BEAT_W-1:0]             data_beat;
  logic [BEAT_W-1:0]             word_sel;
  logic [pAHB_DATA_WIDTH-1:0]    wr_word;
  logic [pAHB_DATA_WIDTH-1:0]    rd_word;

  logic                          unused_ok;
  assign unused_ok = ^{I_hready, I_hresp[pAHB_HRESP_WIDTH-1:1]};

  function automatic logic [pAHB_DATA_WIDTH-1:0] swap_bytes(
    input logic [pAHB_DATA_WIDTH-1:0] w
  );
    logic [pAHB_DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NBYTES; i++) begin
      r[i*8 +: 8] = w[(NBYTES-1-i)*8 +: 8];
    end
    return r;
  endfunction

`ifdef DATA_WORKER_TIMEOUT_EN
  // Consecutive wait states seen on the current phase; cleared whenever the
  // slave is ready so each beat gets its own allowance.
  localparam int WAIT_W = $clog2(pMAX_TRANSFER_WAIT_COUNT + 1);
  logic [WAIT_W-1:0] wait_q;
  logic              bus_active;
  logic              timeout_hit;

  assign bus_active  = (state_q == ST_ADDR) || (state_q == ST_BURST) ||
                       (state_q == ST_LAST);
  assign timeout_hit = bus_active && !I_hreadyout &&
                       (wait_q == WAIT_W'(pMAX_TRANSFER_WAIT_COUNT - 1));

  always_ff @(posedge clk) begin
    if (rst_n || !bus_active || I_hreadyout) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_q + WAIT_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (pMAX_TRANSFER_WAIT_COUNT > 0);
`endif

  // Address phase of beat n overlaps the data phase of beat n-1, so in BURST
  // the beat being transferred on the data bus is one behind beat_q; LAST is
  // the trailing data phase of the final beat.
  always_comb begin
    data_phase = (state_q == ST_BURST) || (state_q == ST_LAST);
    data_beat  = (state_q == ST_LAST) ? LAST_BEAT : (beat_q - BEAT_W'(1));
    word_sel   = (pREVERSE_WORD_ORDER != 0) ? (LAST_BEAT - data_beat) : data_beat;
    capture    = data_phase && I_hreadyout && !I_hresp[0] && !write_q;

    wr_word = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (word_sel == BEAT_W'(i)) begin
        wr_word = wdata_q[i*pAHB_DATA_WIDTH +: pAHB_DATA_WIDTH];
      end
    end
    if (pREVERSE_BYTE_ORDER != 0) begin
      wr_word = swap_bytes(wr_word);
    end

    rd_word = (pREVERSE_BYTE_ORDER != 0) ? swap_bytes(I_hrdata) : I_hrdata;
  end

  // Next-state logic. An ERROR response in any data phase abandons the rest
  // of the burst and goes straight to DONE, which drives HTRANS IDLE.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    accept    = 1'b0;
    finish_ok = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (I_go && armed_q) begin
          accept  = 1'b1;
          beat_d  = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (I_hreadyout) begin
          beat_d  = beat_q + BEAT_W'(1);
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (I_hresp[0]) begin
          state_d = ST_DONE;
        end else if (I_hreadyout) begin
          if (beat_q == LAST_BEAT) begin
            state_d = ST_LAST;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_LAST: begin
        if (I_hresp[0]) begin
          state_d = ST_DONE;
        end else if (I_hreadyout) begin
          state_d   = ST_DONE;
          finish_ok = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifdef DATA_WORKER_TIMEOUT_EN
    if (timeout_hit) begin
      state_d   = ST_DONE;
      finish_ok = 1'b0;
    end
`endif
  end

  // armed_q blocks a held-high I_go from repeating the job: it only comes
  // back once I_go has been seen low.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      armed_q  <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (accept) begin
        addr_q   <= I_int_addr;
        wdata_q  <= I_int_wdata;
        write_q  <= I_int_write;
        rvalid_q <= 1'b0;
      end
      if (finish_ok && !write_q) begin
        rvalid_q <= 1'b1;
      end
      if (accept) begin
        armed_q <= 1'b0;
      end else if (!I_go) begin
        armed_q <= 1'b1;
      end
      for (int i = 0; i < BEATS; i++) begin
        if (capture && (word_sel == BEAT_W'(i))) begin
          rdata_q[i*pAHB_DATA_WIDTH +: pAHB_DATA_WIDTH] <= rd_word;
        end
      end
    end
  end

  // Bus outputs decode straight from registered state, so a stall (state and
  // beat held) freezes every one of them.
  always_comb begin
    O_htrans    = TRANS_IDLE;
    O_haddr     = '0;
    O_hwrite    = 1'b0;
    O_hburst    = '0;
    O_hsize     = '0;
    O_hprot     = '0;
    O_hmastlock = 1'b0;
    O_hnonsec   = 1'b0;
    O_hwdata    = '0;
    if (state_q != ST_IDLE) begin
      O_haddr     = addr_q + (pAHB_ADDR_WIDTH'(beat_q) << ADDR_SHIFT);
      O_hwrite    = write_q;
      O_hburst    = pAHB_HBURST_VALUE;
      O_hsize     = pAHB_HSIZE_VALUE;
      O_hprot     = pAHB_HPROT_VALUE;
      O_hmastlock = pAHB_HMASTLOCK_VALUE;
      O_hnonsec   = pAHB_HNONSEC_VALUE;
    end
    if (state_q == ST_ADDR) begin
      O_htrans = TRANS_NONSEQ;
    end else if (state_q == ST_BURST) begin
      O_htrans = TRANS_SEQ;
    end
    if (data_phase) begin
      O_hwdata = wr_word;
    end
  end

  assign O_done            = (state_q == ST_DONE);
  assign O_int_rdata       = rdata_q;
  assign O_int_rdata_valid = rvalid_q;

endmodule

// File: tb/tb_data_worker.sv
// -----------------------------------------------------------------------------
// tb_data_worker
//
// Directed bench for data_worker in its default configuration (word order
// reversed, bytes not swapped, timeout disabled). Inputs change 1 time unit
// after each rising clock edge and outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_data_worker;

  logic         clk;
  logic         rst_n;
  logic         I_go;
  logic         I_int_write;
  logic [31:0]  I_int_addr;
  logic [127:0] I_int_wdata;
  logic [127:0] O_int_rdata;
  logic         O_int_rdata_valid;
  logic         O_done;
  logic [31:0]  O_haddr;
  logic [2:0]   O_hburst;
  logic         O_hmastlock;
  logic [3:0]   O_hprot;
  logic         O_hnonsec;
  logic [2:0]   O_hsize;
  logic [1:0]   O_htrans;
  logic [31:0]  O_hwdata;
  logic         O_hwrite;
  logic [31:0]  I_hrdata;
  logic         I_hreadyout;
  logic         I_hready;
  logic [1:0]   I_hresp;

  int compared;
  int mismatched;
  int done_at;
  int nonseq_count;
  int done_count;

  logic [31:0] wr_words [4];
  logic [31:0] rd_words [4];

  data_worker dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .I_go              (I_go),
    .I_int_write       (I_int_write),
    .I_int_addr        (I_int_addr),
    .I_int_wdata       (I_int_wdata),
    .O_int_rdata       (O_int_rdata),
    .O_int_rdata_valid (O_int_rdata_valid),
    .O_done            (O_done),
    .O_haddr           (O_haddr),
    .O_hburst          (O_hburst),
    .O_hmastlock       (O_hmastlock),
    .O_hprot           (O_hprot),
    .O_hnonsec         (O_hnonsec),
    .O_hsize           (O_hsize),
    .O_htrans          (O_htrans),
    .O_hwdata          (O_hwdata),
    .O_hwrite          (O_hwrite),
    .I_hrdata          (I_hrdata),
    .I_hreadyout       (I_hreadyout),
    .I_hready          (I_hready),
    .I_hresp           (I_hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic go, input logic write,
                               input logic [31:0] addr, input logic [127:0] wdata);
    I_go        = go;
    I_int_write = write;
    I_int_addr  = addr;
    I_int_wdata = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    rst_n       = 1'b1;
    I_hrdata    = '0;
    I_hreadyout = 1'b1;
    I_hready    = 1'b1;
    I_hresp     = 2'b00;
    applyStimulus(1'b0, 1'b0, 32'h0, 128'h0);

    // Reset state
    tick();
    tick();
    checkOutput("rst_htrans", O_htrans, 2'b00);
    checkOutput("rst_haddr", O_haddr, 32'h0);
    checkOutput("rst_hburst", O_hburst, 3'b000);
    checkOutput("rst_hwrite", O_hwrite, 1'b0);
    checkOutput("rst_done", O_done, 1'b0);
    checkOutput("rst_rvalid", O_int_rdata_valid, 1'b0);
    rst_n = 1'b0;
    tick();

    // Write burst at 0x08, no wait states
    $display("[TB] write burst");
    wr_words[0] = 32'h31c30019;
    wr_words[1] = 32'h67d4acf1;
    wr_words[2] = 32'hbcb25768;
    wr_words[3] = 32'h708627ae;
    applyStimulus(1'b1, 1'b1, 32'h08, 128'h31c3001967d4acf1bcb25768708627ae);
    done_at = 0;
    for (int t = 1; t <= 12 && done_at == 0; t++) begin
      tick();
      if (t == 1) begin
        checkOutput("wr_htrans_b0", O_htrans, 2'b10);
        checkOutput("wr_haddr_b0", O_haddr, 32'h08);
        checkOutput("wr_hwrite", O_hwrite, 1'b1);
        checkOutput("wr_hburst", O_hburst, 3'b011);
        checkOutput("wr_hsize", O_hsize, 3'b010);
        checkOutput("wr_hprot", O_hprot, 4'b0011);
        checkOutput("wr_hmastlock", O_hmastlock, 1'b1);
        checkOutput("wr_hnonsec", O_hnonsec, 1'b0);
      end
      if (t >= 2 && t <= 4) begin
        checkOutput("wr_htrans_seq", O_htrans, 2'b11);
        checkOutput("wr_haddr_seq", O_haddr, 32'h08 + 4 * (t - 1));
      end
      if (t >= 2 && t <= 5) begin
        checkOutput("wr_hwdata", O_hwdata, wr_words[t-2]);
      end
      if (t == 5) begin
        checkOutput("wr_htrans_last", O_htrans, 2'b00);
      end
      if (O_done) done_at = t;
    end
    checkOutput("wr_done_cycle", done_at, 6);
    checkOutput("wr_rvalid", O_int_rdata_valid, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 128'h0);
    tick();
    checkOutput("wr_done_pulse", O_done, 1'b0);
    checkOutput("wr_idle_haddr", O_haddr, 32'h0);
    checkOutput("wr_idle_hwrite", O_hwrite, 1'b0);

    // Read burst at 0x08, no wait states
    $display("[TB] read burst");
    rd_words[0] = 32'h11111111;
    rd_words[1] = 32'h22222222;
    rd_words[2] = 32'h33333333;
    rd_words[3] = 32'h44444444;
    applyStimulus(1'b1, 1'b0, 32'h08, 128'h0);
    done_at = 0;
    for (int t = 1; t <= 12 && done_at == 0; t++) begin
      tick();
      if (t == 1) begin
        checkOutput("rd_htrans_b0", O_htrans, 2'b10);
        checkOutput("rd_hwrite", O_hwrite, 1'b0);
      end
      if (t >= 2 && t <= 5) I_hrdata = rd_words[t-2];
      if (O_done) done_at = t;
    end
    checkOutput("rd_done_cycle", done_at, 6);
    checkOutput("rd_rvalid", O_int_rdata_valid, 1'b1);
    checkOutput("rd_rdata", O_int_rdata, 128'h11111111222222223333333344444444);
    applyStimulus(1'b0, 1'b0, 32'h0, 128'h0);
    tick();
    checkOutput("rd_done_pulse", O_done, 1'b0);
    checkOutput("rd_rvalid_hold", O_int_rdata_valid, 1'b1);

    // Read burst at 0x100 with three wait states during beat 2
    $display("[TB] stalled read");
    rd_words[0] = 32'haaaaaaaa;
    rd_words[1] = 32'hbbbbbbbb;
    rd_words[2] = 32'hcccccccc;
    rd_words[3] = 32'hdddddddd;
    applyStimulus(1'b1, 1'b0, 32'h100, 128'h0);
    done_at = 0;
    for (int t = 1; t <= 20 && done_at == 0; t++) begin
      tick();
      case (t)
        1: checkOutput("st_rvalid_clear", O_int_rdata_valid, 1'b0);
        2: I_hrdata = rd_words[0];
        3: begin I_hrdata = rd_words[1]; I_hreadyout = 1'b0; end
        6: I_hreadyout = 1'b1;
        7: I_hrdata = rd_words[2];
        8: I_hrdata = rd_words[3];
        default: ;
      endcase
      if (t >= 4 && t <= 6) begin
        checkOutput("st_htrans_hold", O_htrans, 2'b11);
        checkOutput("st_haddr_hold", O_haddr, 32'h108);
      end
      if (t == 7) checkOutput("st_haddr_b3", O_haddr, 32'h10c);
      if (O_done) done_at = t;
    end
    checkOutput("st_done_cycle", done_at, 9);
    checkOutput("st_rvalid", O_int_rdata_valid, 1'b1);
    checkOutput("st_rdata", O_int_rdata, 128'haaaaaaaabbbbbbbbccccccccdddddddd);
    I_hreadyout = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 128'h0);
    tick();

    // Read burst at 0x200 with ERROR in the beat 1 data phase
    $display("[TB] error response");
    applyStimulus(1'b1, 1'b0, 32'h200, 128'h0);
    done_at = 0;
    for (int t = 1; t <= 12 && done_at == 0; t++) begin
      tick();
      if (t == 2) I_hrdata = 32'h55555555;
      if (t == 3) I_hresp = 2'b01;
      if (O_done) begin
        done_at = t;
        checkOutput("err_htrans_idle", O_htrans, 2'b00);
        checkOutput("err_rvalid", O_int_rdata_valid, 1'b0);
      end
    end
    checkOutput("err_done_cycle", done_at, 4);
    I_hresp = 2'b00;
    applyStimulus(1'b0, 1'b0, 32'h0, 128'h0);
    tick();
    checkOutput("err_done_pulse", O_done, 1'b0);
    checkOutput("err_rvalid_after", O_int_rdata_valid, 1'b0);

    // I_go held high well past completion runs the job once
    $display("[TB] held request");
    applyStimulus(1'b1, 1'b1, 32'h40, 128'h0123456789abcdef0011223344556677);
    nonseq_count = 0;
    done_count   = 0;
    for (int t = 1; t <= 36; t++) begin
      tick();
      if (O_htrans == 2'b10) nonseq_count++;
      if (O_done) done_count++;
    end
    checkOutput("hold_nonseq_count", nonseq_count, 1);
    checkOutput("hold_done_count", done_count, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 128'h0);
    tick();

    // Reset in the middle of a write burst, then a clean read
    $display("[TB] reset mid-burst");
    applyStimulus(1'b1, 1'b1, 32'h80, 128'hdeadbeefcafef00d0badc0de12345678);
    tick();
    tick();
    tick();
    checkOutput("mr_htrans_pre", O_htrans, 2'b11);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 128'h0);
    tick();
    checkOutput("mr_htrans", O_htrans, 2'b00);
    checkOutput("mr_haddr", O_haddr, 32'h0);
    checkOutput("mr_hwdata", O_hwdata, 32'h0);
    checkOutput("mr_hwrite", O_hwrite, 1'b0);
    checkOutput("mr_hburst", O_hburst, 3'b000);
    checkOutput("mr_hprot", O_hprot, 4'b0000);
    checkOutput("mr_hmastlock", O_hmastlock, 1'b0);
    checkOutput("mr_done", O_done, 1'b0);
    rst_n = 1'b0;
    done_count = 0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (O_done) done_count++;
    end
    checkOutput("mr_no_done", done_count, 0);

    rd_words[0] = 32'h01234567;
    rd_words[1] = 32'h89abcdef;
    rd_words[2] = 32'hfedcba98;
    rd_words[3] = 32'h76543210;
    applyStimulus(1'b1, 1'b0, 32'h30, 128'h0);
    done_at = 0;
    for (int t = 1; t <= 12 && done_at == 0; t++) begin
      tick();
      if (t >= 2 && t <= 5) I_hrdata = rd_words[t-2];
      if (t == 3) checkOutput("mr_haddr_b2", O_haddr, 32'h38);
      if (O_done) done_at = t;
    end
    checkOutput("mr_done_cycle", done_at, 6);
    checkOutput("mr_rvalid", O_int_rdata_valid, 1'b1);
    checkOutput("mr_rdata", O_int_rdata, 128'h0123456789abcdeffedcba9876543210);
    applyStimulus(1'b0, 1'b0, 32'h0, 128'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
